// File: rtl/mult_cpa_stage.sv
// Final carry-propagate stage of the 32b multiplier: resolves the CSA {sum, carry} pair
// into a 64b product over two stages (low half, then high half). Optional macro: MULT_CPA_FLUSH_EN.
module mult_cpa_stage #(
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [63:0]      i_sum,
  input  logic [63:0]      i_carry,
  input  logic [1:0]       i_op,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag
`ifdef MULT_CPA_FLUSH_EN
  ,
  input  logic             i_flush
`endif
);

  // Handshake: a transfer happens on any edge where valid & ready are both high;
  // a producer holds valid and data stable until that edge, and ready never
  // looks at the valid it is paired with.

  logic             s1_valid;
  logic             s2_valid;
  logic [31:0]      s1_lo;
  logic             s1_c32;
  logic [31:0]      s1_sum_hi;
  logic [31:0]      s1_carry_hi;
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic             flush;
  logic             accept;
  logic             s1_adv;
  logic [32:0]      lo_sum;
  logic [31:0]      hi_sum;

`ifdef MULT_CPA_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  assign o_ready = (!s1_valid || !s2_valid || i_ready) && !flush;
  assign accept  = i_valid && o_ready;
  assign s1_adv  = s1_valid && (!s2_valid || i_ready) && !flush;
  assign o_valid = s2_valid;

  assign lo_sum = {1'b0, i_sum[31:0]} + {1'b0, i_carry[31:0]};
  // Carry out of bit 63 falls off the 32b sum by construction.
  assign hi_sum = s1_sum_hi + s1_carry_hi + {31'd0, s1_c32};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid    <= 1'b0;
      s1_lo       <= '0;
      s1_c32      <= 1'b0;
      s1_sum_hi   <= '0;
      s1_carry_hi <= '0;
      s1_op       <= '0;
      s1_tag      <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid    <= 1'b1;
      s1_lo       <= lo_sum[31:0];
      s1_c32      <= lo_sum[32];
      s1_sum_hi   <= i_sum[63:32];
      s1_carry_hi <= i_carry[63:32];
      s1_op       <= i_op;
      s1_tag      <= i_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      o_result <= '0;
      o_tag    <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      o_result <= (s1_op == 2'b00) ? s1_lo : hi_sum;
      o_tag    <= s1_tag;
    end else if (i_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_cpa_stage.sv
// Self-checking bench for mult_cpa_stage: directed corner cases plus randomized traffic
// scored against a full-width 64b product model.
module tb_mult_cpa_stage;

  localparam int TAG_W = 5;
  localparam int EW    = TAG_W + 32;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [63:0]      i_sum;
  logic [63:0]      i_carry;
  logic [1:0]       i_op;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_result;
  logic [TAG_W-1:0] o_tag;
`ifdef MULT_CPA_FLUSH_EN
  logic             i_flush;
`endif

  mult_cpa_stage #(.TAG_W(TAG_W)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sum    (i_sum),
    .i_carry  (i_carry),
    .i_op     (i_op),
    .i_tag    (i_tag),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_tag    (o_tag)
`ifdef MULT_CPA_FLUSH_EN
    ,
    .i_flush  (i_flush)
`endif
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic          hold_pend = 1'b0;
  logic [EW-1:0] hold_val;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
    end
  endtask

  // Reference: the whole 64b product in one addition, then pick the word.
  function automatic logic [EW-1:0] model(input logic [63:0] s, input logic [63:0] c,
                                          input logic [1:0] op, input logic [TAG_W-1:0] tag);
    logic [63:0] p;
    logic [31:0] r;
    p = s + c;
    r = (op == 2'b00) ? p[31:0] : p[63:32];
    return {tag, r};
  endfunction

  always @(negedge i_clk) begin
    logic [EW-1:0] e;
    if (!i_rst_n) begin
      hold_pend = 1'b0;
    end
`ifdef MULT_CPA_FLUSH_EN
    else if (i_flush) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end
`endif
    else begin
      if (hold_pend) begin
        check("hold_valid", {63'd0, o_valid}, 64'd1);
        check("hold_data", {27'd0, o_tag, o_result}, {27'd0, hold_val});
      end
      hold_pend = o_valid && !i_ready;
      hold_val  = {o_tag, o_result};
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {27'd0, o_tag, o_result}, 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("result", {27'd0, o_tag, o_result}, {27'd0, e});
        end
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_sum, i_carry, i_op, i_tag));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [63:0] s, input logic [63:0] c,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag);
    i_sum   = s;
    i_carry = c;
    i_op    = op;
    i_tag   = tag;
    i_valid = 1'b1;
  endtask

  // Presents one item and returns #1 after the edge that accepts it; valid stays high.
  task automatic send(input logic [63:0] s, input logic [63:0] c,
                      input logic [1:0] op, input logic [TAG_W-1:0] tag);
    logic ok;
    set_in(s, c, op, tag);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge i_clk);
      ok = o_ready;
      @(posedge i_clk);
      #1;
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycles(1);
    cycles(2);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 4))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h0000_0000_FFFF_FFFF;
      2:       return 64'd1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_sum   = '0;
    i_carry = '0;
    i_op    = '0;
    i_tag   = '0;
`ifdef MULT_CPA_FLUSH_EN
    i_flush = 1'b0;
`endif
    cycles(3);
    check("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_o_result", {32'd0, o_result}, 64'd0);
    check("rst_o_tag", {59'd0, o_tag}, 64'd0);
    i_rst_n = 1'b1;
    cycles(1);
    check("rst_o_ready", {63'd0, o_ready}, 64'd1);

    // single item, latency of two edges
    send(64'd15, 64'd0, 2'b00, 5'd3);
    i_valid = 1'b0;
    check("lat_n1_valid", {63'd0, o_valid}, 64'd0);
    cycles(1);
    check("lat_n2_valid", {63'd0, o_valid}, 64'd1);
    check("lat_result", {32'd0, o_result}, 64'd15);
    check("lat_tag", {59'd0, o_tag}, 64'd3);
    cycles(1);

    // carry across bit 32, and carry out of bit 63 dropped
    send(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b00, 5'd5);
    send(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b11, 5'd6);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b01, 5'd7);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 5'd8);
    drain();

    // stall with both stages full, then in-order release
    i_ready = 1'b0;
    send(64'd100, 64'd1, 2'b00, 5'd1);
    send(64'h1234_0000_8000_0000, 64'h0000_0001_8000_0000, 2'b11, 5'd2);
    set_in(64'd300, 64'd3, 2'b00, 5'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("stall_o_ready", {63'd0, o_ready}, 64'd0);
      check("stall_o_valid", {63'd0, o_valid}, 64'd1);
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    send(64'd300, 64'd3, 2'b00, 5'd3);
    send(64'hABCD_0000_0000_0000, 64'h0, 2'b01, 5'd4);
    drain();

    // reset while both stages hold data
    i_ready = 1'b0;
    send(64'd11, 64'd0, 2'b00, 5'd9);
    send(64'd12, 64'd0, 2'b00, 5'd10);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("midrst_o_valid", {63'd0, o_valid}, 64'd0);
    check("midrst_o_result", {32'd0, o_result}, 64'd0);
    check("midrst_o_tag", {59'd0, o_tag}, 64'd0);
    exp_q.delete();
    cycles(1);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    send(64'd42, 64'd8, 2'b00, 5'd11);
    drain();

`ifdef MULT_CPA_FLUSH_EN
    i_ready = 1'b0;
    send(64'd21, 64'd0, 2'b00, 5'd12);
    send(64'd22, 64'd0, 2'b00, 5'd13);
    set_in(64'd23, 64'd0, 2'b00, 5'd14);
    i_flush = 1'b1;
    @(negedge i_clk);
    check("flush_o_ready", {63'd0, o_ready}, 64'd0);
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("flush_o_valid", {63'd0, o_valid}, 64'd0);
      cycles(1);
    end
`endif

    // randomized traffic with back-pressure; valid held until accepted
    i_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge i_clk);
      acc = i_valid && o_ready;
      @(posedge i_clk);
      #1;
      if (!i_valid || acc) begin
        if ($urandom_range(0, 3) != 0)
          set_in(rnd64(), rnd64(), 2'($urandom_range(0, 3)), TAG_W'($urandom()));
        else
          i_valid = 1'b0;
      end
      i_ready = ($urandom_range(0, 2) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
